// File: rtl/sdi_eye_sampler.sv
// sdi_eye_sampler
//   Turns the demodulator's interpolated I/Q stream plus its on-time symbol
//   strobe into the eye-diagram stream for the SDI capture stage. The block
//   aligns to a symbol boundary and decimates by decim+1. Every emitted
//   sample is tagged with its kept-sample offset from the last boundary.
//   Loss of symbol timing is flagged and the block re-aligns.
//
// Optional feature (macro SDI_EYE_ROUND_EN):
//   defined   - iEye/qEye are rounded to their 16 MSBs (+2, saturate at
//               +max, bits [1:0] cleared).
//   undefined - iEye/qEye pass iIn/qIn through unmodified.
//
// Ports:
//   clk, nReset        clock, async active-low reset
//   enable             1 = run, 0 = forced to IDLE
//   decim[3:0]         keep one of every decim+1 samples
//   sampleEn, symEn    input sample strobe, on-time marker
//   iIn, qIn           I/Q samples (two's complement)
//   eyeSync            one-clk output-valid strobe
//   iEye, qEye         eye samples (held while eyeSync=0)
//   eyeOffset          kept-sample index since last boundary (held)
//   symPeriod          kept samples in last complete symbol period
//   locked             1 while in RUN
//   symLost            one-clk pulse on loss of symbol timing
module sdi_eye_sampler #(
  parameter int DATA_W = 18,
  parameter int OFS_W  = 5
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              enable,
  input  logic [3:0]        decim,
  input  logic              sampleEn,
  input  logic              symEn,
  input  logic [DATA_W-1:0] iIn,
  input  logic [DATA_W-1:0] qIn,
  output logic              eyeSync,
  output logic [DATA_W-1:0] iEye,
  output logic [DATA_W-1:0] qEye,
  output logic [OFS_W-1:0]  eyeOffset,
  output logic [OFS_W-1:0]  symPeriod,
  output logic              locked,
  output logic              symLost
);

  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_e;

  localparam logic [OFS_W-1:0] OFS_MAX = '1;

  state_e            state_q;
  logic [3:0]        dcnt_q;
  // Offset of the most recently emitted sample. The next kept sample gets
  // ofs_q+1. The timing is lost when a kept sample would exceed OFS_MAX.
  logic [OFS_W-1:0]  ofs_q, ofs_nxt_d;
  logic              eyeSync_q, locked_q, symLost_q;
  logic [DATA_W-1:0] iEye_q, qEye_q, i_d, q_d;
  logic [OFS_W-1:0]  eyeOffset_q, symPeriod_q;

`ifdef SDI_EYE_ROUND_EN
  // Round to nearest on the 16 MSBs. Only a positive input can overflow
  // when 2 is added, so the result saturates to +max with the low bits
  // cleared.
  function automatic logic [DATA_W-1:0] rnd(input logic [DATA_W-1:0] x);
    logic [DATA_W:0] s;
    s = {x[DATA_W-1], x} + (DATA_W+1)'(2);
    if (s[DATA_W] != s[DATA_W-1]) rnd = {1'b0, {(DATA_W-3){1'b1}}, 2'b00};
    else                          rnd = {s[DATA_W-1:2], 2'b00};
  endfunction
  assign i_d = rnd(iIn);
  assign q_d = rnd(qIn);
`else
  assign i_d = iIn;
  assign q_d = qIn;
`endif

  assign ofs_nxt_d = ofs_q + 1'b1;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      ofs_q       <= '0;
      eyeSync_q   <= 1'b0;
      iEye_q      <= '0;
      qEye_q      <= '0;
      eyeOffset_q <= '0;
      symPeriod_q <= '0;
      locked_q    <= 1'b0;
      symLost_q   <= 1'b0;
    end else begin
      eyeSync_q <= 1'b0;
      symLost_q <= 1'b0;
      if (!enable) begin
        state_q  <= IDLE;
        dcnt_q   <= '0;
        ofs_q    <= '0;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: state_q <= ALIGN;
          ALIGN: begin
            if (sampleEn && symEn) begin
              eyeSync_q   <= 1'b1;
              iEye_q      <= i_d;
              qEye_q      <= q_d;
              eyeOffset_q <= '0;
              ofs_q       <= '0;
              dcnt_q      <= '0;
              locked_q    <= 1'b1;
              state_q     <= RUN;
            end
          end
          RUN: begin
            if (sampleEn) begin
              if (symEn) begin
                // In RUN a symbol always closes a period that was opened by
                // an earlier symbol. The aligning symbol never latches one.
                // A 32-sample period cannot be represented, so it saturates.
                symPeriod_q <= (ofs_q == OFS_MAX) ? OFS_MAX : ofs_nxt_d;
                eyeSync_q   <= 1'b1;
                iEye_q      <= i_d;
                qEye_q      <= q_d;
                eyeOffset_q <= '0;
                ofs_q       <= '0;
                dcnt_q      <= '0;
              end else if (dcnt_q == decim) begin
                dcnt_q <= '0;
                if (ofs_q == OFS_MAX) begin
                  symLost_q <= 1'b1;
                  locked_q  <= 1'b0;
                  ofs_q     <= '0;
                  state_q   <= ALIGN;
                end else begin
                  eyeSync_q   <= 1'b1;
                  iEye_q      <= i_d;
                  qEye_q      <= q_d;
                  eyeOffset_q <= ofs_nxt_d;
                  ofs_q       <= ofs_nxt_d;
                end
              end else begin
                dcnt_q <= dcnt_q + 4'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign eyeSync   = eyeSync_q;
  assign iEye      = iEye_q;
  assign qEye      = qEye_q;
  assign eyeOffset = eyeOffset_q;
  assign symPeriod = symPeriod_q;
  assign locked    = locked_q;
  assign symLost   = symLost_q;

endmodule

// File: tb/tb_sdi_eye_sampler.sv
// Directed bench for sdi_eye_sampler. It covers alignment and offsets,
// decimation, loss of timing, enable drop, async reset and the optional
// rounding feature.
module tb_sdi_eye_sampler;
  localparam int DATA_W = 18;
  localparam int OFS_W  = 5;

  logic              clk = 1'b0;
  logic              nReset, enable, sampleEn, symEn;
  logic [3:0]        decim;
  logic [DATA_W-1:0] iIn, qIn;
  logic              eyeSync, locked, symLost;
  logic [DATA_W-1:0] iEye, qEye;
  logic [OFS_W-1:0]  eyeOffset, symPeriod;

  int checks = 0;
  int errors = 0;

  sdi_eye_sampler #(.DATA_W(DATA_W), .OFS_W(OFS_W)) dut (
    .clk(clk), .nReset(nReset), .enable(enable), .decim(decim),
    .sampleEn(sampleEn), .symEn(symEn), .iIn(iIn), .qIn(qIn),
    .eyeSync(eyeSync), .iEye(iEye), .qEye(qEye), .eyeOffset(eyeOffset),
    .symPeriod(symPeriod), .locked(locked), .symLost(symLost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one input sample. The outputs are settled on return.
  task automatic step(input logic se, input logic sy, input logic [DATA_W-1:0] i,
                      input logic [DATA_W-1:0] q);
    @(negedge clk);
    sampleEn = se; symEn = sy; iIn = i; qIn = q;
    @(posedge clk);
    #1;
  endtask

  initial begin
    nReset = 1'b0; enable = 1'b0; decim = 4'd0;
    sampleEn = 1'b0; symEn = 1'b0; iIn = '0; qIn = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sync",   32'(eyeSync),   32'd0);
    chk("rst_iEye",   32'(iEye),      32'd0);
    chk("rst_ofs",    32'(eyeOffset), 32'd0);
    chk("rst_period", 32'(symPeriod), 32'd0);
    chk("rst_locked", 32'(locked),    32'd0);
    chk("rst_lost",   32'(symLost),   32'd0);

    // Align and offsets: decim=0, symEn every 8th sample.
    @(negedge clk); nReset = 1'b1; enable = 1'b1;
    step(1'b0, 1'b0, '0, '0);                     // IDLE -> ALIGN
    step(1'b1, 1'b0, 18'd77, 18'd77);             // ALIGN, no symbol yet
    chk("align_nosym_sync", 32'(eyeSync), 32'd0);
    chk("align_nosym_lock", 32'(locked),  32'd0);
    for (int n = 0; n < 24; n++) begin
      step(1'b1, (n % 8) == 0, 18'(n), 18'(n + 100));
      chk("t1_sync", 32'(eyeSync),   32'd1);
      chk("t1_ofs",  32'(eyeOffset), 32'(n % 8));
      chk("t1_i",    32'(iEye),      32'(n));
      chk("t1_q",    32'(qEye),      32'(n + 100));
      chk("t1_lock", 32'(locked),    32'd1);
      if (n == 0) chk("t1_period_first", 32'(symPeriod), 32'd0);
      if (n == 8) chk("t1_period",       32'(symPeriod), 32'd8);
    end

    // Decimation by 2, symEn every 8th sample.
    decim = 4'd1;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, (k % 8) == 0, 18'(200 + k), 18'd0);
      if ((k % 2) == 0) begin
        chk("t2_sync", 32'(eyeSync),   32'd1);
        chk("t2_ofs",  32'(eyeOffset), 32'((k % 8) / 2));
        chk("t2_i",    32'(iEye),      32'(200 + k));
      end else begin
        chk("t2_drop", 32'(eyeSync), 32'd0);
        chk("t2_hold", 32'(iEye),    32'(200 + k - 1));
      end
      if (k == 0) chk("t2_period8", 32'(symPeriod), 32'd8);
      if (k == 8) chk("t2_period4", 32'(symPeriod), 32'd4);
    end
    // symEn every 7th sample. Each symbol lands mid-count and is still kept.
    for (int j = 0; j < 14; j++) begin
      step(1'b1, (j % 7) == 0, 18'(400 + j), 18'd0);
      if (((j % 7) % 2) == 0) begin
        chk("t2b_sync", 32'(eyeSync),   32'd1);
        chk("t2b_ofs",  32'(eyeOffset), 32'((j % 7) / 2));
      end else begin
        chk("t2b_drop", 32'(eyeSync), 32'd0);
      end
      if (j == 7) chk("t2b_period", 32'(symPeriod), 32'd4);
    end

    // Loss of timing.
    decim = 4'd0;
    step(1'b1, 1'b1, 18'd500, 18'd0);
    chk("t3_sym_ofs", 32'(eyeOffset), 32'd0);
    chk("t3_period",  32'(symPeriod), 32'd4);
    for (int m = 1; m < 32; m++) begin
      step(1'b1, 1'b0, 18'(500 + m), 18'd0);
      chk("t3_sync", 32'(eyeSync),   32'd1);
      chk("t3_ofs",  32'(eyeOffset), 32'(m));
    end
    step(1'b1, 1'b0, 18'd600, 18'd0);
    chk("t3_lost_sync", 32'(eyeSync), 32'd0);
    chk("t3_lost",      32'(symLost), 32'd1);
    chk("t3_lost_lock", 32'(locked),  32'd0);
    chk("t3_lost_hold", 32'(iEye),    32'd531);
    step(1'b1, 1'b0, 18'd601, 18'd0);
    chk("t3_lost_pulse", 32'(symLost), 32'd0);
    chk("t3_align_sync", 32'(eyeSync), 32'd0);
    step(1'b1, 1'b1, 18'd602, 18'd0);
    chk("t3_realign_sync",   32'(eyeSync),   32'd1);
    chk("t3_realign_ofs",    32'(eyeOffset), 32'd0);
    chk("t3_realign_lock",   32'(locked),    32'd1);
    chk("t3_realign_period", 32'(symPeriod), 32'd4);

    // Enable drop when the next sample would be offset 5.
    for (int m = 1; m < 5; m++) begin
      step(1'b1, 1'b0, 18'(300 + m), 18'd0);
      chk("t4_ofs", 32'(eyeOffset), 32'(m));
    end
    enable = 1'b0;
    step(1'b1, 1'b0, 18'd999, 18'd0);
    chk("t4_sync", 32'(eyeSync), 32'd0);
    chk("t4_lock", 32'(locked),  32'd0);
    chk("t4_lost", 32'(symLost), 32'd0);
    chk("t4_hold", 32'(iEye),    32'd304);
    enable = 1'b1;
    step(1'b1, 1'b1, 18'd700, 18'd0);             // still IDLE on this edge
    chk("t4_idle_sync", 32'(eyeSync), 32'd0);
    step(1'b1, 1'b0, 18'd701, 18'd0);
    chk("t4_align_sync", 32'(eyeSync), 32'd0);
    step(1'b1, 1'b1, 18'd702, 18'd0);
    chk("t4_re_sync", 32'(eyeSync),   32'd1);
    chk("t4_re_ofs",  32'(eyeOffset), 32'd0);
    chk("t4_re_i",    32'(iEye),      32'd702);

    // Async reset between clock edges while running.
    step(1'b1, 1'b0, 18'd703, 18'd0);
    chk("t5_pre_ofs", 32'(eyeOffset), 32'd1);
    @(negedge clk); #2; nReset = 1'b0; #1;
    chk("t5_sync",   32'(eyeSync),   32'd0);
    chk("t5_iEye",   32'(iEye),      32'd0);
    chk("t5_ofs",    32'(eyeOffset), 32'd0);
    chk("t5_period", 32'(symPeriod), 32'd0);
    chk("t5_lock",   32'(locked),    32'd0);
    enable = 1'b0;
    @(negedge clk); nReset = 1'b1;
    step(1'b1, 1'b1, 18'd800, 18'd0);
    chk("t5_noen_sync", 32'(eyeSync), 32'd0);
    enable = 1'b1;
    step(1'b1, 1'b1, 18'd801, 18'd0);
    chk("t5_idle_sync", 32'(eyeSync), 32'd0);
    step(1'b1, 1'b1, 18'd802, 18'd0);
    chk("t5_re_sync",   32'(eyeSync),   32'd1);
    chk("t5_re_ofs",    32'(eyeOffset), 32'd0);
    chk("t5_re_lock",   32'(locked),    32'd1);
    chk("t5_re_period", 32'(symPeriod), 32'd0);

    // Rounding feature, or pass-through in the default build.
    step(1'b1, 1'b1, 18'h1FFFE, 18'h00006);
    chk("t6_sync",   32'(eyeSync),   32'd1);
    chk("t6_period", 32'(symPeriod), 32'd1);
`ifdef SDI_EYE_ROUND_EN
    chk("t6_i_sat", 32'(iEye), 32'h1FFFC);
    chk("t6_q_rnd", 32'(qEye), 32'h00008);
`else
    chk("t6_i_pass", 32'(iEye), 32'h1FFFE);
    chk("t6_q_pass", 32'(qEye), 32'h00006);
`endif
    step(1'b1, 1'b1, 18'h3FFFF, 18'h20001);
`ifdef SDI_EYE_ROUND_EN
    chk("t6_i_neg", 32'(iEye), 32'h00000);
    chk("t6_q_neg", 32'(qEye), 32'h20000);
`else
    chk("t6_i_neg", 32'(iEye), 32'h3FFFF);
    chk("t6_q_neg", 32'(qEye), 32'h20001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
